// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Queues ALU requests in a small FIFO and issues them one at a
//            time to an external combinational ALU. Each result is returned
//            as a held valid/ready response, in the order it was accepted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk, rst_n                      clock, synchronous active-low reset
//            req_valid/req_ready/req_op/a/b  request handshake and payload
//            alu_operand1/2, alu_operation,
//            alu_enable                      registered drive to the ALU
//            alu_result                      combinational ALU output
//            rsp_valid/rsp_ready/rsp_data/
//            rsp_err                         response handshake and payload
//            busy                            sequencer active or queue non-empty
// Options  : ALU_SEQ_DIVZERO_CHECK_EN - when defined, a divide (op 111) with
//            b == 0 is not sent to the ALU; it answers 8'hFF with rsp_err=1.
// ============================================================================
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    output logic [2:0] alu_operation,
    output logic       alu_enable,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam int             c_AW   = $clog2(FIFO_DEPTH);
    localparam int             c_EW   = 19;  // {op[2:0], a[7:0], b[7:0]}
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_RESP  = 2'd2;

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [c_EW-1:0] w_head;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    // Readiness is purely "not full": a pop on the same edge never opens a
    // slot for a request arriving while the queue is full.
    assign req_ready = rst_n & ~w_full;
    assign w_push    = req_valid & req_ready;
    // The head leaves the queue either from IDLE or straight out of a
    // completing response handshake, which gives one response per 2 cycles.
    assign w_pop  = ~w_empty & ((r_state == c_IDLE) | ((r_state == c_RESP) & rsp_ready));
    assign w_head = r_mem[r_rd_ptr];
    assign busy   = (r_state != c_IDLE) | ~w_empty;

`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    logic w_dz;
    logic r_dz;
    assign w_dz = (w_head[18:16] == 3'b111) & (w_head[7:0] == 8'h00);
`else
    assign rsp_err = 1'b0;
`endif

    // Storage needs no reset: occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {req_op, req_a, req_b};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            alu_operand1  <= 8'h00;
            alu_operand2  <= 8'h00;
            alu_operation <= 3'b000;
            alu_enable    <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'h00;
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
            rsp_err       <= 1'b0;
            r_dz          <= 1'b0;
`endif
        end else begin
            // Loading the ALU is common to both pop sources (IDLE and RESP).
            if (w_pop) begin
                alu_operation <= w_head[18:16];
                alu_operand1  <= w_head[15:8];
                alu_operand2  <= w_head[7:0];
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                alu_enable    <= ~w_dz;
                r_dz          <= w_dz;
`else
                alu_enable    <= 1'b1;
`endif
            end
            case (r_state)
                c_IDLE: begin
                    if (w_pop) r_state <= c_ISSUE;
                end
                c_ISSUE: begin
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
                    rsp_data <= r_dz ? 8'hFF : alu_result;
                    rsp_err  <= r_dz;
`else
                    rsp_data <= alu_result;
`endif
                    alu_enable <= 1'b0;
                    rsp_valid  <= 1'b1;
                    r_state    <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= w_pop ? c_ISSUE : c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer. Supplies a behavioural
//            ALU, keeps a transaction-level model of the request queue and
//            response stream, and compares DUT outputs every cycle plus a few
//            hand-computed literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] req_op = 3'b0;
    logic [7:0] req_a = 8'h0;
    logic [7:0] req_b = 8'h0;
    logic [7:0] alu_operand1;
    logic [7:0] alu_operand2;
    logic [2:0] alu_operation;
    logic       alu_enable;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    alu_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_operation(alu_operation), .alu_enable(alu_enable),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Plain arithmetic ALU; a zero divisor yields a recognisable marker.
    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b011:  return a + b;
            3'b100:  return a - b;
            3'b010:  return 8'((16'(a) * 16'(b)));
            3'b111:  return (b == 8'h00) ? 8'hEE : a / b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit is_dz(input req_t r);
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        return (r.op == 3'b111) && (r.b == 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    always_comb alu_result = alu_f(alu_operation, alu_operand1, alu_operand2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_q holds every accepted request not yet answered (in-flight one first).
    req_t       m_q[$];
    int         m_qlen = 0;   // entries still waiting in the queue
    int         m_have = 0;   // 0 nothing in flight, 1 being issued, 2 response held
    logic [7:0] m_a = 0, m_b = 0, m_rsp = 0;
    logic [2:0] m_op = 0;
    logic       m_err = 0;
    bit         m_dz = 0;

    always @(posedge clk) begin
        bit   push, consume, pop;
        int   nh;
        req_t h;
        if (!rst_n) begin
            m_q.delete();
            m_qlen = 0; m_have = 0;
            m_a = 0; m_b = 0; m_op = 0; m_rsp = 0; m_err = 0; m_dz = 0;
        end else begin
            push    = req_valid && (m_qlen < DEPTH);
            consume = (m_have == 2) && rsp_ready;
            pop     = (m_qlen > 0) && (m_have == 0 || consume);
            nh      = m_have;
            if (m_have == 1) begin
                h = m_q[0];
                m_rsp = is_dz(h) ? 8'hFF : alu_f(h.op, h.a, h.b);
                m_err = is_dz(h);
                nh = 2;
            end
            if (consume) begin
                void'(m_q.pop_front());
                nh = 0;
            end
            if (pop) begin
                h = m_q[0];
                m_op = h.op; m_a = h.a; m_b = h.b; m_dz = is_dz(h);
                nh = 1;
            end
            if (push) m_q.push_back('{req_op, req_a, req_b});
            m_qlen = m_qlen + int'(push) - int'(pop);
            m_have = nh;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",     32'(req_ready),     32'(rst_n && (m_qlen < DEPTH)));
            chk("rsp_valid",     32'(rsp_valid),     32'(m_have == 2));
            chk("alu_enable",    32'(alu_enable),    32'(m_have == 1 && !m_dz));
            chk("alu_operation", 32'(alu_operation), 32'(m_op));
            chk("alu_operand1",  32'(alu_operand1),  32'(m_a));
            chk("alu_operand2",  32'(alu_operand2),  32'(m_b));
            chk("rsp_data",      32'(rsp_data),      32'(m_rsp));
            chk("rsp_err",       32'(rsp_err),       32'(m_err));
            chk("busy",          32'(busy),          32'(m_have != 0 || m_qlen != 0));
        end
    end

    // ---------------- stimulus ----------------
    task automatic push1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Single request into an idle block: check latency and the literal result.
    task automatic directed(input string nm, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] expv);
        rsp_ready = 1'b0;
        push1(op, a, b);
        @(posedge clk); #1;
        chk({nm, "_lat1_valid"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_lat2_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_data"},       32'(rsp_data),  32'(expv));
        chk({nm, "_err"},        32'(rsp_err),   32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({nm, "_done"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input string nm);
        int t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk); #1; t++;
        end
        if (!rsp_valid) chk({nm, "_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        int k, t;
        // reset
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready),    32'd0);
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),    32'd0);
        chk("rst_operand1",  32'(alu_operand1), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // arithmetic and truncation
        directed("add", 3'b011, 8'd3,  8'd5,  8'd8);
        directed("sub", 3'b100, 8'd3,  8'd5,  8'hFE);
        directed("mul", 3'b010, 8'd20, 8'd13, 8'h04);
        directed("rsv", 3'b001, 8'd7,  8'd9,  8'h00);

        // full queue: 5 back-to-back, first is popped, 4 remain queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 3'b011; req_a = 8'(i); req_b = 8'd10;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("full_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        k = 0; t = 0;
        while (k < 5 && t < 40) begin
            if (rsp_valid) begin
                chk("full_order", 32'(rsp_data), 32'(10 + k));
                k++;
            end
            @(posedge clk); #1; t++;
        end
        chk("full_count", 32'(k), 32'd5);
        rsp_ready = 1'b0;
        @(posedge clk); #1;

        // reset while a response is held with 3 still queued
        for (int i = 0; i < 4; i++) push1(3'b100, 8'(50 + i), 8'd1);
        wait_valid("rstmid");
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rstmid_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_busy",  32'(busy),      32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("rstmid_stale", 32'(rsp_valid), 32'd0);

        // simultaneous push and pop with 2 queued
        for (int i = 0; i < 3; i++) push1(3'b011, 8'(100 + i), 8'd0);
        wait_valid("pp");
        req_valid = 1'b1; req_op = 3'b011; req_a = 8'd103; req_b = 8'd0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        k = 1; t = 0;
        while (k < 4 && t < 40) begin
            if (rsp_valid) begin
                chk("pp_order", 32'(rsp_data), 32'(100 + k));
                k++;
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            t++;
        end
        chk("pp_count", 32'(k), 32'd4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 2) == 0;
            req_op    = 3'($urandom);
            req_a     = 8'($urandom);
            req_b     = (($urandom % 8) == 0) ? 8'h00 : 8'($urandom);
            rsp_ready = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("drain_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
